irq_priority_encoder: RTL

- Parametrised, registered priority encoder with per-channel pending latches, a mask and a valid/ready output handshake.
- Sits between raw event/interrupt lines and a consumer (CPU stub, DMA sequencer) that services one channel index at a time.
- Highest index has highest priority.
- Adds edge capture, masking, holding of the winner until accepted, and clear-on-accept.

---
 rtl/irq_priority_encoder_pkg.sv | 18 +
 rtl/irq_priority_encoder_if.sv | 26 ++
 rtl/prio_find_msb.sv | 26 ++
 rtl/irq_priority_encoder.sv | 101 ++++++++++
 4 files changed

// File: rtl/irq_priority_encoder_pkg.sv
// Shared state encoding and elaboration helpers for the interrupt priority
// encoder and the arbiters that reuse its highest-set-bit search.
package irq_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_t;

  // Width of an index able to address 'value' distinct entries.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/irq_priority_encoder_if.sv
// Grant channel from the priority encoder to its consumer: the encoder
// presents an index with out_valid and the consumer accepts it with out_ready.
interface irq_priority_encoder_if #(
  parameter int N = 8
);
  import irq_pkg::*;

  localparam int W = clog2(N);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;

  modport master (
    output out_valid,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/prio_find_msb.sv
// Combinational search for the highest set bit of a vector; found is low
// and idx is zero when the vector is empty.
module prio_find_msb
  import irq_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_priority_encoder.sv
// Registered priority encoder: captures request edges (or levels) into
// pending bits, masks them and hands the highest channel to a consumer.
module irq_priority_encoder
  import irq_pkg::*;
#(
  parameter int N         = 8,
  parameter int EDGE_MODE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           mask,
  irq_priority_encoder_if.master grant,
  output logic [N-1:0]           pending,
  output logic                   any_pending
);

  localparam int W = clog2(N);

  irq_state_t   state;
  irq_state_t   state_next;
  logic [N-1:0] req_d;
  logic [N-1:0] hold;
  logic [N-1:0] clr;
  logic [N-1:0] cand;
  logic [N-1:0] pending_next;
  logic [W-1:0] idx_q;
  logic [W-1:0] idx_next;
  logic [W-1:0] win_idx;
  logic         win_found;
  logic         accept;

  assign grant.out_valid = (state == PRESENT);
  assign grant.out_idx   = idx_q;
  assign accept          = grant.out_valid && grant.out_ready;

  // Excluding the channel on display lets the following winner be picked in
  // the same cycle it is accepted, giving one grant per clock.
  assign hold = grant.out_valid ? (N'(1) << idx_q) : '0;
  assign clr  = accept ? hold : '0;
  assign cand = pending & mask & ~hold;

  // A rising edge in the accept cycle re-sets the bit being cleared.
  always_comb begin
    pending_next = req;
    if (EDGE_MODE != 0) begin
      pending_next = (pending & ~clr) | (req & ~req_d);
    end
  end

  prio_find_msb #(
    .N (N)
  ) u_find (
    .vec   (cand),
    .idx   (win_idx),
    .found (win_found)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    idx_next   = idx_q;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next = PRESENT;
          idx_next   = win_idx;
        end
      end
      PRESENT: begin
        if (grant.out_ready) begin
          if (win_found) begin
            idx_next = win_idx;
          end else begin
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx_q       <= '0;
      req_d       <= '0;
      pending     <= '0;
      any_pending <= 1'b0;
    end else begin
      state       <= state_next;
      idx_q       <= idx_next;
      req_d       <= req;
      pending     <= pending_next;
      any_pending <= |(pending & mask);
    end
  end

endmodule
